// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment display path.
// Provides the BCD digit type, converter FSM states and the add-3 digit adjustment.
package seg_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } conv_state_t;

    function automatic bcd_digit_t bcd_adj(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done conversion handshake between a requester and bin_to_bcd_seq.
// Optional macro BCD_SIGNED_EN adds the negative result flag.
interface bin_to_bcd_seq_if #(
    parameter int IN_WIDTH   = 16,
    parameter int NUM_DIGITS = 5
);
    logic                       start;
    logic [IN_WIDTH-1:0]        bin_in;
    logic                       busy;
    logic                       done;
    logic [NUM_DIGITS-1:0][3:0] bcd_out;
    logic                       overflow;
`ifdef BCD_SIGNED_EN
    logic                       negative;
`endif

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
`ifdef BCD_SIGNED_EN
        input  negative,
`endif
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
`ifdef BCD_SIGNED_EN
        output negative,
`endif
        output overflow
    );

endinterface

// File: rtl/bcd_digit_slice.sv
// One BCD nibble of the double-dabble datapath: add-3 adjust, then shift left by one.
// Purely combinational; carry_out is the bit leaving this digit towards the next one.
module bcd_digit_slice
    import seg_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       carry_in,
    output bcd_digit_t next_digit,
    output logic       carry_out
);

    bcd_digit_t adjusted;

    assign adjusted   = bcd_adj(digit);
    assign next_digit = {adjusted[2:0], carry_in};
    assign carry_out  = adjusted[3];

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock; done arrives IN_WIDTH+1 cycles after start.
// start is ignored while busy (no queuing); macro BCD_SIGNED_EN converts two's complement input.
module bin_to_bcd_seq
    import seg_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_WIDTH - 1);
    localparam logic [NUM_DIGITS-1:0][3:0] ALL_NINES = {NUM_DIGITS{4'd9}};

    conv_state_t state;
    conv_state_t state_next;

    logic                          load;
    logic                          step;
    logic                          finish;

    logic [IN_WIDTH-1:0]           shift_reg;
    bcd_digit_t [NUM_DIGITS-1:0]   scratch;
    bcd_digit_t [NUM_DIGITS-1:0]   scratch_next;
    logic [NUM_DIGITS:0]           carry;
    logic [CNT_W-1:0]              bit_cnt;
    logic                          ovf_sticky;
    logic                          ovf_final;
    logic [IN_WIDTH-1:0]           magnitude;

    logic                          done_reg;
    logic [NUM_DIGITS-1:0][3:0]    bcd_reg;
    logic                          overflow_reg;

`ifdef BCD_SIGNED_EN
    logic                          sign_bit;
    logic                          sign_reg;
    logic                          negative_reg;

    // Two's complement negate; the most negative value wraps to its correct unsigned magnitude.
    assign sign_bit  = bus.bin_in[IN_WIDTH-1];
    assign magnitude = sign_bit ? (~bus.bin_in + 1'b1) : bus.bin_in;
`else
    assign magnitude = bus.bin_in;
`endif

    // Shift chain: the shift register MSB enters digit 0, each digit feeds the next.
    assign carry[0] = shift_reg[IN_WIDTH-1];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_slice u_slice (
            .digit      (scratch[g]),
            .carry_in   (carry[g]),
            .next_digit (scratch_next[g]),
            .carry_out  (carry[g+1])
        );
    end

    // A bit leaving the top digit in the final iteration counts too.
    assign ovf_final = ovf_sticky | carry[NUM_DIGITS];

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg    <= '0;
            scratch      <= '0;
            bit_cnt      <= '0;
            ovf_sticky   <= 1'b0;
            done_reg     <= 1'b0;
            bcd_reg      <= '0;
            overflow_reg <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_reg     <= 1'b0;
            negative_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                shift_reg  <= magnitude;
                scratch    <= '0;
                bit_cnt    <= '0;
                ovf_sticky <= 1'b0;
`ifdef BCD_SIGNED_EN
                sign_reg   <= sign_bit;
`endif
            end
            if (step) begin
                shift_reg  <= {shift_reg[IN_WIDTH-2:0], 1'b0};
                scratch    <= scratch_next;
                bit_cnt    <= bit_cnt + 1'b1;
                ovf_sticky <= ovf_final;
            end
            if (finish) begin
                done_reg     <= 1'b1;
                overflow_reg <= ovf_final;
                bcd_reg      <= ovf_final ? ALL_NINES : scratch_next;
`ifdef BCD_SIGNED_EN
                negative_reg <= sign_reg;
`endif
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_reg;
    assign bus.bcd_out  = bcd_reg;
    assign bus.overflow = overflow_reg;
`ifdef BCD_SIGNED_EN
    assign bus.negative = negative_reg;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance checked every cycle against an arithmetic model.
// Optional macro BCD_SIGNED_EN selects the signed-input expectations.
module tb_bin_to_bcd_seq;

    localparam int IW  = 16;
    localparam int LAT = IW + 1;

    logic clk = 1'b0;
    logic reset;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.IN_WIDTH(IW), .NUM_DIGITS(5)) ifa ();
    bin_to_bcd_seq_if #(.IN_WIDTH(IW), .NUM_DIGITS(4)) ifb ();

    bin_to_bcd_seq #(.IN_WIDTH(IW), .NUM_DIGITS(5)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    bin_to_bcd_seq #(.IN_WIDTH(IW), .NUM_DIGITS(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result packed as {negative, overflow, bcd[19:0]} computed with plain decimal arithmetic.
    function automatic logic [21:0] model(input logic [15:0] x, input int nd);
        int         mag;
        int         lim;
        logic [19:0] bcd;
        logic       ovf;
        logic       neg;
        mag = int'(x);
        neg = 1'b0;
`ifdef BCD_SIGNED_EN
        if (x[15]) begin
            neg = 1'b1;
            mag = 65536 - int'(x);
        end
`endif
        lim = 10 ** nd - 1;
        bcd = '0;
        ovf = 1'b0;
        if (mag > lim) begin
            ovf = 1'b1;
            for (int i = 0; i < nd; i++) bcd[4*i +: 4] = 4'd9;
        end else begin
            for (int i = 0; i < nd; i++) begin
                bcd[4*i +: 4] = 4'(mag % 10);
                mag = mag / 10;
            end
        end
        return {neg, ovf, bcd};
    endfunction

    // Timing model: a conversion occupies IW cycles after acceptance, result appears with done.
    int          rem_a = 0, rem_b = 0;
    logic [15:0] pend_a = '0, pend_b = '0;
    logic [21:0] exp_a = '0, exp_b = '0;
    logic        exp_done_a = 1'b0, exp_done_b = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            rem_a <= 0; exp_a <= '0; exp_done_a <= 1'b0;
        end else begin
            exp_done_a <= 1'b0;
            if (rem_a == 0) begin
                if (ifa.start) begin
                    rem_a  <= IW;
                    pend_a <= ifa.bin_in;
                end
            end else begin
                rem_a <= rem_a - 1;
                if (rem_a == 1) begin
                    exp_a      <= model(pend_a, 5);
                    exp_done_a <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            rem_b <= 0; exp_b <= '0; exp_done_b <= 1'b0;
        end else begin
            exp_done_b <= 1'b0;
            if (rem_b == 0) begin
                if (ifb.start) begin
                    rem_b  <= IW;
                    pend_b <= ifb.bin_in;
                end
            end else begin
                rem_b <= rem_b - 1;
                if (rem_b == 1) begin
                    exp_b      <= model(pend_b, 4);
                    exp_done_b <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_busy", 32'(ifa.busy), 32'(rem_a > 0));
            chk("a_done", 32'(ifa.done), 32'(exp_done_a));
            chk("a_bcd", 32'(ifa.bcd_out), 32'(exp_a[19:0]));
            chk("a_ovf", 32'(ifa.overflow), 32'(exp_a[20]));
            chk("b_busy", 32'(ifb.busy), 32'(rem_b > 0));
            chk("b_done", 32'(ifb.done), 32'(exp_done_b));
            chk("b_bcd", 32'(ifb.bcd_out), 32'(exp_b[15:0]));
            chk("b_ovf", 32'(ifb.overflow), 32'(exp_b[20]));
`ifdef BCD_SIGNED_EN
            chk("a_neg", 32'(ifa.negative), 32'(exp_a[21]));
            chk("b_neg", 32'(ifb.negative), 32'(exp_b[21]));
`endif
            for (int i = 0; i < 5; i++) chk("a_nibble_le9", 32'(ifa.bcd_out[i] <= 4'd9), 32'd1);
            for (int i = 0; i < 4; i++) chk("b_nibble_le9", 32'(ifb.bcd_out[i] <= 4'd9), 32'd1);
        end
    end

    task automatic pulse(input bit sel, input logic [15:0] v);
        @(negedge clk);
        if (sel) begin ifb.start = 1'b1; ifb.bin_in = v; end
        else     begin ifa.start = 1'b1; ifa.bin_in = v; end
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    // Called one cycle after start was driven; cyc is the cycle count from acceptance to done.
    task automatic wait_done(input bit sel, output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while ((sel ? ifb.done : ifa.done) !== 1'b1 && cyc < 40) begin
            if (sel ? ifb.busy : ifa.busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        if (sel ? ifb.busy : ifa.busy) bcnt++;
        chk("done_seen", 32'(sel ? ifb.done : ifa.done), 32'd1);
    endtask

    task automatic count_dones(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (ifa.done) cnt++;
        end
    endtask

    int cyc, bcnt, ndone;

    initial begin
        reset = 1'b1;
        ifa.start = 1'b0; ifa.bin_in = '0;
        ifb.start = 1'b0; ifb.bin_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_bcd", 32'(ifa.bcd_out), 32'd0);
        chk("rst_ovf", 32'(ifa.overflow), 32'd0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Zero converts with the full latency.
        pulse(1'b0, 16'd0);
        wait_done(1'b0, cyc, bcnt);
        chk("zero_latency", 32'(cyc), 32'(LAT));
        chk("zero_bcd", 32'(ifa.bcd_out), 32'h00000);
        chk("zero_ovf", 32'(ifa.overflow), 32'd0);

        // All ones: busy exactly IW cycles.
        pulse(1'b0, 16'hFFFF);
        wait_done(1'b0, cyc, bcnt);
        chk("ffff_busy_cycles", 32'(bcnt), 32'd16);
`ifdef BCD_SIGNED_EN
        chk("ffff_bcd", 32'(ifa.bcd_out), 32'h00001);
        chk("ffff_neg", 32'(ifa.negative), 32'd1);
`else
        chk("ffff_bcd", 32'(ifa.bcd_out), 32'h65535);
`endif
        chk("ffff_ovf", 32'(ifa.overflow), 32'd0);

        // Four-digit instance: overflow saturates to 9999, exact 9999 does not overflow.
        pulse(1'b1, 16'd12345);
        wait_done(1'b1, cyc, bcnt);
        chk("b12345_ovf", 32'(ifb.overflow), 32'd1);
        chk("b12345_bcd", 32'(ifb.bcd_out), 32'h9999);
        pulse(1'b1, 16'd9999);
        wait_done(1'b1, cyc, bcnt);
        chk("b9999_ovf", 32'(ifb.overflow), 32'd0);
        chk("b9999_bcd", 32'(ifb.bcd_out), 32'h9999);

        // Start while busy is dropped.
        pulse(1'b0, 16'd1234);
        repeat (4) @(negedge clk);
        ifa.start = 1'b1; ifa.bin_in = 16'd4321;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_done(1'b0, cyc, bcnt);
        chk("busy_start_bcd", 32'(ifa.bcd_out), 32'h01234);
        count_dones(25, ndone);
        chk("busy_start_no_2nd_done", 32'(ndone), 32'd0);

        // Start in the done cycle is accepted.
        pulse(1'b0, 16'd555);
        wait_done(1'b0, cyc, bcnt);
        chk("b2b_first_bcd", 32'(ifa.bcd_out), 32'h00555);
        ifa.start = 1'b1; ifa.bin_in = 16'd42;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_done(1'b0, cyc, bcnt);
        chk("b2b_latency", 32'(cyc), 32'(LAT));
        chk("b2b_bcd", 32'(ifa.bcd_out), 32'h00042);

        // Reset mid-conversion aborts without a done pulse.
        pulse(1'b0, 16'd500);
        wait_done(1'b0, cyc, bcnt);
        chk("c500_bcd", 32'(ifa.bcd_out), 32'h00500);
        pulse(1'b0, 16'd777);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(ifa.busy), 32'd0);
        chk("abort_bcd", 32'(ifa.bcd_out), 32'h00000);
        chk("abort_done", 32'(ifa.done), 32'd0);
        count_dones(25, ndone);
        chk("abort_no_done", 32'(ndone), 32'd0);

`ifdef BCD_SIGNED_EN
        pulse(1'b0, 16'hFB2E);
        wait_done(1'b0, cyc, bcnt);
        chk("neg1234_bcd", 32'(ifa.bcd_out), 32'h01234);
        chk("neg1234_neg", 32'(ifa.negative), 32'd1);
        pulse(1'b0, 16'h8000);
        wait_done(1'b0, cyc, bcnt);
        chk("neg32768_bcd", 32'(ifa.bcd_out), 32'h32768);
        chk("neg32768_neg", 32'(ifa.negative), 32'd1);
        pulse(1'b0, 16'd321);
        wait_done(1'b0, cyc, bcnt);
        chk("pos321_neg", 32'(ifa.negative), 32'd0);
`else
        pulse(1'b0, 16'hFB2E);
        wait_done(1'b0, cyc, bcnt);
        chk("fb2e_bcd", 32'(ifa.bcd_out), 32'h64302);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
